// File: rtl/masked_randomness_source.sv
// masked_randomness_source
// Fresh-randomness generator for HPC3 multiplier chains. A bank of 32-bit
// Galois LFSRs is seeded over a valid/ready handshake, warmed up for a fixed
// number of advancing cycles, and then its concatenated state is sliced into
// the mask r and the two p masks (A*B and C*B multiplications).
module masked_randomness_source #(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 1,
  parameter int UNROLL        = 32,
  parameter int WARMUP_CYCLES = 4,
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2,
  localparam int QW            = NUM_QUADRATIC * BIT_WIDTH,
  localparam int N_OUT         = 3 * QW,
  localparam int NUM_LFSR      = (N_OUT + 31) / 32
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic [32*NUM_LFSR-1:0]   in_seed,
  input  logic                     in_seed_valid,
  output logic                     out_seed_ready,
  input  logic                     in_enable,
  output logic [QW-1:0]            out_r,
  output logic [QW-1:0]            out_p_ab,
  output logic [QW-1:0]            out_p_cb,
  output logic                     out_valid
);

  localparam int SW    = 32 * NUM_LFSR;
  localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

  typedef enum logic [1:0] {
    UNSEEDED,
    WARMUP,
    RUN
  } state_e;

  state_e             fsmState_q, fsmState_d;
  logic [SW-1:0]      lfsrState_q, lfsrState_d;
  logic [CNT_W-1:0]   warmCnt_q, warmCnt_d;

  logic [SW-1:0]      advancedState;
  logic [SW-1:0]      guardedSeed;
  logic               seedFire;

  // One advance is UNROLL Galois steps of x^32+x^22+x^2+x+1, unrolled in logic.
  function automatic logic [31:0] advanceWord(input logic [31:0] word);
    logic [31:0] s;
    s = word;
    for (int i = 0; i < UNROLL; i++) begin
      if (s[0]) s = (s >> 1) ^ 32'h80200003;
      else      s = s >> 1;
    end
    return s;
  endfunction

  // Advance every LFSR word and substitute 1 for any all-zero seed word,
  // since an all-zero Galois LFSR would stay stuck at zero forever.
  always_comb begin
    advancedState = '0;
    guardedSeed   = '0;
    for (int k = 0; k < NUM_LFSR; k++) begin
      advancedState[k*32 +: 32] = advanceWord(lfsrState_q[k*32 +: 32]);
      if (in_seed[k*32 +: 32] == 32'h0) guardedSeed[k*32 +: 32] = 32'h1;
      else                              guardedSeed[k*32 +: 32] = in_seed[k*32 +: 32];
    end
  end

  // Seed is accepted only while idle or running; warm-up ignores new seeds.
  always_comb begin
    out_seed_ready = (fsmState_q == UNSEEDED) || (fsmState_q == RUN);
    out_valid      = (fsmState_q == RUN);
    seedFire       = in_seed_valid && out_seed_ready;
  end

  // Next-state logic: a seed fire always wins over enable, warm-up advances
  // unconditionally, and RUN advances only when the consumer asks for fresh bits.
  always_comb begin
    fsmState_d  = fsmState_q;
    lfsrState_d = lfsrState_q;
    warmCnt_d   = warmCnt_q;
    case (fsmState_q)
      UNSEEDED: begin
        if (seedFire) begin
          lfsrState_d = guardedSeed;
          warmCnt_d   = '0;
          fsmState_d  = WARMUP;
        end
      end
      WARMUP: begin
        lfsrState_d = advancedState;
        warmCnt_d   = warmCnt_q + 1'b1;
        if (warmCnt_q == CNT_W'(WARMUP_CYCLES - 1)) fsmState_d = RUN;
      end
      RUN: begin
        if (seedFire) begin
          lfsrState_d = guardedSeed;
          warmCnt_d   = '0;
          fsmState_d  = WARMUP;
        end else if (in_enable) begin
          lfsrState_d = advancedState;
        end
      end
      default: begin
        fsmState_d  = UNSEEDED;
        lfsrState_d = '0;
        warmCnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset that dominates seed and enable.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      fsmState_q  <= UNSEEDED;
      lfsrState_q <= '0;
      warmCnt_q   <= '0;
    end else begin
      fsmState_q  <= fsmState_d;
      lfsrState_q <= lfsrState_d;
      warmCnt_q   <= warmCnt_d;
    end
  end

  // Masks are wired straight from the LFSR state; top unused bits never leave.
  always_comb begin
    out_r    = lfsrState_q[0      +: QW];
    out_p_ab = lfsrState_q[QW     +: QW];
    out_p_cb = lfsrState_q[2*QW   +: QW];
  end

endmodule
